// File: rtl/fft_pkg.sv
// Shared constants, complex word type and bin-order helper for the 16-point FFT.
// Output reordering is selected by the FFT_BITREV_EN macro in fft_bitrev_addr.
package fft_pkg;

    localparam int FFT_N      = 16;
    localparam int FFT_LOG2N  = 4;
    localparam int FFT_DATA_W = 32;
    localparam int FFT_HALF_W = 16;

    typedef struct packed {
        logic signed [FFT_HALF_W-1:0] re;
        logic signed [FFT_HALF_W-1:0] im;
    } cplx_t;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } unl_state_e;

    function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] a);
        return {a[0], a[1], a[2], a[3]};
    endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Beat counter to buffer word index. FFT_BITREV_EN defined: bit-reversed
// lookup (natural frequency order out); undefined: pass-through order.
module fft_bitrev_addr
    import fft_pkg::*;
(
    input  logic [FFT_LOG2N-1:0] cnt_i,
    output logic [FFT_LOG2N-1:0] addr_o
);

`ifdef FFT_BITREV_EN
    assign addr_o = bitrev4(cnt_i);
`else
    assign addr_o = cnt_i;
`endif

endmodule

// File: rtl/fft_result_unloader.sv
// Captures a full 16-bin frame in one cycle and streams it out one bin per beat.
// Bin ordering depends on FFT_BITREV_EN (see fft_bitrev_addr).
module fft_result_unloader
    import fft_pkg::*;
#(
    parameter int N      = FFT_N,
    parameter int DATA_W = FFT_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N*DATA_W-1:0]          in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [FFT_HALF_W-1:0] out_real,
    output logic signed [FFT_HALF_W-1:0] out_imag,
    output logic [FFT_LOG2N-1:0]         out_index,
    output logic                         out_last
);

    unl_state_e           state_q, state_d;
    logic [FFT_LOG2N-1:0] cnt_q, cnt_d;
    cplx_t [N-1:0]        buf_q;
    logic [FFT_LOG2N-1:0] rd_addr;
    cplx_t                sel;
    logic                 accept;
    logic                 last_beat;

    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt_q == FFT_LOG2N'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else if (accept) begin
            buf_q <= in_data;
        end
    end

    // in_ready opens during STREAM only on the final handshake, so the next
    // frame lands in the same edge that retires bin 15.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_STREAM;
                    cnt_d   = '0;
                end
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last_beat) begin
                        in_ready = 1'b1;
                        cnt_d    = '0;
                        if (!in_valid) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    fft_bitrev_addr u_addr (
        .cnt_i  (cnt_q),
        .addr_o (rd_addr)
    );

    assign sel       = buf_q[rd_addr];
    assign out_real  = sel.re;
    assign out_imag  = sel.im;
    assign out_index = cnt_q;
    assign out_last  = last_beat;

endmodule

// File: tb/tb_fft_result_unloader.sv
// Scoreboard bench for fft_result_unloader: stimulus pushes expected beats,
// a negedge monitor compares every presented beat against the queue head.
module tb_fft_result_unloader;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [3:0]  idx;
        logic        last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_real;
    logic [15:0]  out_imag;
    logic [3:0]   out_index;
    logic         out_last;

    int    tests = 0;
    int    fails = 0;
    int    beats = 0;
    bit    stall_mode = 1'b0;
    beat_t sb[$];

    always #5 clk = ~clk;

    fft_result_unloader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_index (out_index),
        .out_last  (out_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rev4(input int x);
        int r = 0;
        for (int b = 0; b < 4; b++) if (x[b]) r |= (1 << (3 - b));
        return r;
    endfunction

    function automatic int order(input int i);
`ifdef FFT_BITREV_EN
        return rev4(i);
`else
        return i;
`endif
    endfunction

    function automatic logic [511:0] frame_ramp();
        logic [511:0] f;
        for (int k = 0; k < 16; k++) f[k*32 +: 32] = {16'(k * 256), 16'(-k)};
        return f;
    endfunction

    function automatic logic [511:0] frame_b();
        logic [511:0] f;
        for (int k = 0; k < 16; k++) f[k*32 +: 32] = {16'(k * 16 + 1), 16'(k) ^ 16'hA5A5};
        return f;
    endfunction

    function automatic logic [511:0] frame_ext();
        logic [511:0] f;
        f[31:0] = 32'h8000_7FFF;
        f[63:32] = 32'h7FFF_8000;
        for (int k = 2; k < 16; k++) f[k*32 +: 32] = {16'(k) | 16'h8000, 16'hFFFF};
        return f;
    endfunction

    // Ramp frame expectations are computed from the formula, others by slicing.
    task automatic push_frame(input logic [511:0] f, input bit ramp);
        beat_t e;
        int    m;
        for (int i = 0; i < 16; i++) begin
            m = order(i);
            if (ramp) begin
                e.re = 16'(m * 256);
                e.im = 16'(-m);
            end else begin
                e.re = f[m*32 + 16 +: 16];
                e.im = f[m*32 +: 16];
            end
            e.idx  = 4'(i);
            e.last = (i == 15);
            sb.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [511:0] f, input bit ramp);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = f;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            #1;
            if (in_ready) begin
                push_frame(f, ramp);
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bit [3:0] pat = 4'b1001;
        int       ph  = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                out_ready = pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {28'd0, out_index}, 32'hFFFF);
            end else begin
                chk("out_real", {16'd0, out_real}, {16'd0, sb[0].re});
                chk("out_imag", {16'd0, out_imag}, {16'd0, sb[0].im});
                chk("out_index", {28'd0, out_index}, {28'd0, sb[0].idx});
                chk("out_last", {31'd0, out_last}, {31'd0, sb[0].last});
                if (out_ready) begin
                    void'(sb.pop_front());
                    beats++;
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_real", {16'd0, out_real}, 32'd0);
        chk("rst_out_imag", {16'd0, out_imag}, 32'd0);
        chk("rst_out_index", {28'd0, out_index}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_frame(frame_ramp(), 1'b1);
        drain();
        chk("beats_frame1", 32'(beats), 32'd16);

        stall_mode = 1'b1;
        send_frame(frame_b(), 1'b0);
        drain();
        stall_mode = 1'b0;
        chk("beats_stall", 32'(beats), 32'd32);
        repeat (2) @(posedge clk);
        #1;

        send_frame(frame_ramp(), 1'b1);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            #1;
            if (c == 10) begin
                in_valid = 1'b1;
                in_data  = frame_b();
            end
            chk("b2b_valid", {31'd0, out_valid}, 32'd1);
            chk("b2b_in_ready", {31'd0, in_ready}, {31'd0, (c % 16) == 15});
            if (c == 15 && in_ready) push_frame(frame_b(), 1'b0);
            if (c == 16) in_valid = 1'b0;
        end
        drain();
        chk("beats_b2b", 32'(beats), 32'd64);

        send_frame(frame_ramp(), 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_index", {28'd0, out_index}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        send_frame(frame_ramp(), 1'b1);
        drain();

        send_frame(frame_ext(), 1'b0);
        drain();
        chk("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
